// File: rtl/wishbone_master_if.sv
// Request/response port and Wishbone classic bus signals for wishbone_master.
// The master modport is the DUT view; the slave modport is the environment view.
interface wishbone_master_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [15:0] req_adr;
  logic [7:0]  req_dat;
  logic        rsp_valid;
  logic [7:0]  rsp_dat;
  logic        rsp_err;
  logic [15:0] adr_o;
  logic        we_o;
  logic        stb_o;
  logic        cyc_o;
  logic [7:0]  dat_o;
  logic [7:0]  dat_i;
  logic        ack_i;

  modport master (
    input  req_valid, req_we, req_adr, req_dat, dat_i, ack_i,
    output req_ready, rsp_valid, rsp_dat, rsp_err, adr_o, we_o, stb_o, cyc_o, dat_o
  );

  modport slave (
    output req_valid, req_we, req_adr, req_dat, dat_i, ack_i,
    input  req_ready, rsp_valid, rsp_dat, rsp_err, adr_o, we_o, stb_o, cyc_o, dat_o
  );
endinterface

// File: rtl/wishbone_master.sv
// Single-outstanding Wishbone classic master fed by a valid/ready request port.
// Define WB_MASTER_TIMEOUT_EN to abort unacknowledged transfers after TIMEOUT cycles.
module wishbone_master #(
  parameter int TIMEOUT = 16
) (
  input logic               clk_i,
  input logic               rst_i,
  wishbone_master_if.master bus
);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [15:0] adr_q;
  logic        we_q;
  logic [7:0]  dat_q;
  logic [7:0]  rsp_dat_q;
  logic        accept;
  logic        ack;
  logic        timed_out;
  logic        done;
  logic        req_ready;
  logic        bus_active;
  logic        rsp_valid;

  if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
    $error("wishbone_master: TIMEOUT must be in 2..255");
  end

  // A floating (X/Z) acknowledge from an unaddressed slave must not count.
  assign ack    = (bus.ack_i === 1'b1);
  assign accept = bus.req_valid && req_ready;
  assign done   = (state == BUS) && (ack || timed_out);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    bus_active = 1'b0;
    rsp_valid  = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (bus.req_valid) state_nxt = BUS;
      end
      BUS: begin
        bus_active = 1'b1;
        if (ack || timed_out) state_nxt = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef WB_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT);

  logic [CNT_W-1:0] cnt;
  logic             rsp_err_q;

  // The counter parks at TIMEOUT-1 instead of wrapping; it is cleared on every accept.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                         cnt <= '0;
    else if (accept)                   cnt <= '0;
    else if (state == BUS && !timed_out) cnt <= cnt + CNT_W'(1);
  end

  assign timed_out = (cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)     rsp_err_q <= 1'b0;
    else if (done) rsp_err_q <= !ack;
  end

  assign bus.rsp_err = rsp_err_q;
`else
  assign timed_out   = 1'b0;
  assign bus.rsp_err = 1'b0;
`endif

  // we_o is cleared when the transfer ends so it is only ever high during BUS.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      adr_q     <= 16'h0000;
      we_q      <= 1'b0;
      dat_q     <= 8'h00;
      rsp_dat_q <= 8'h00;
    end else begin
      if (accept) begin
        adr_q <= bus.req_adr;
        we_q  <= bus.req_we;
        dat_q <= bus.req_we ? bus.req_dat : 8'h00;
      end else if (done) begin
        we_q  <= 1'b0;
      end
      if (done) rsp_dat_q <= (ack && !we_q) ? bus.dat_i : 8'h00;
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.cyc_o     = bus_active;
  assign bus.stb_o     = bus_active;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_dat   = rsp_dat_q;
  assign bus.adr_o     = adr_q;
  assign bus.we_o      = we_q;
  assign bus.dat_o     = dat_q;

endmodule

// File: tb/tb_wishbone_master.sv
// Scoreboard bench for wishbone_master: a memory-backed slave model answers the bus,
// a transaction-level reference model predicts every response and its cycle.
module tb_wishbone_master;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wishbone_master_if bus();
  wishbone_master #(.TIMEOUT(TO)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  typedef struct {
    logic        we;
    logic [15:0] adr;
    logic [7:0]  wdat;
    logic [7:0]  dat;
    logic        err;
    int          rcyc;
  } exp_t;

  exp_t       q[$];
  int         tests = 0;
  int         fails = 0;
  int         cyc = 0;
  logic [7:0] smem [65536] = '{default: 8'h00};
  logic [7:0] mmem [65536] = '{default: 8'h00};
  int         nxt_dly = 0;
  int         cur_dly = 0;
  int         wcnt = 0;
  logic [7:0] last_dat = 8'h00;
  logic       last_err = 1'b0;
  int         acc_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Slave model: slaves exist for adr[15:12] = 0..7 and acknowledge after cur_dly wait cycles.
  always @(posedge clk) begin
    if (bus.req_valid && bus.req_ready) begin
      cur_dly <= nxt_dly;
      wcnt    <= 0;
    end else if (bus.stb_o) begin
      wcnt <= wcnt + 1;
    end
    if (bus.stb_o && bus.ack_i === 1'b1 && bus.we_o) smem[bus.adr_o] <= bus.dat_o;
  end

  always_comb begin
    bus.ack_i = 1'b0;
    bus.dat_i = 8'hEE;
    if (bus.cyc_o && bus.stb_o && !bus.adr_o[15] && wcnt == cur_dly) begin
      bus.ack_i = 1'b1;
      bus.dat_i = bus.we_o ? ~bus.dat_o : smem[bus.adr_o];
    end
  end

  // Reference model: outcome and accept-to-response latency of one request.
  function automatic void model(input logic we, input logic [15:0] adr, input logic [7:0] wd,
                                input int dly, output logic [7:0] d, output logic e, output int lat);
    bit ok;
    ok = !adr[15];
`ifdef WB_MASTER_TIMEOUT_EN
    ok = ok && (dly < TO);
`endif
    if (ok) begin
      e   = 1'b0;
      lat = dly + 1;
      d   = we ? 8'h00 : mmem[adr];
      if (we) mmem[adr] = wd;
    end else begin
      e   = 1'b0;
      lat = 1000000;
`ifdef WB_MASTER_TIMEOUT_EN
      e   = 1'b1;
      lat = TO;
`endif
      d   = 8'h00;
    end
  endfunction

  task automatic issue(input logic we, input logic [15:0] adr, input logic [7:0] wd,
                       input int dly, input bit hold);
    exp_t e;
    int   lat;
    int   n;
    n = 0;
    bus.req_we    = we;
    bus.req_adr   = adr;
    bus.req_dat   = wd;
    bus.req_valid = 1'b1;
    nxt_dly       = dly;
    @(negedge clk);
    while (!bus.req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("accept_wait", int'(bus.req_ready), 1);
    if (!bus.req_ready) begin
      bus.req_valid = 1'b0;
      return;
    end
    acc_cyc = cyc + 1;
    model(we, adr, wd, dly, e.dat, e.err, lat);
    e.we   = we;
    e.adr  = adr;
    e.wdat = wd;
    e.rcyc = acc_cyc + lat;
    q.push_back(e);
    @(posedge clk);
    #1;
    if (!hold) bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    chk("drain", q.size(), 0);
    #1;
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst) begin
      chk("ready_only_idle", int'(bus.req_ready && (bus.cyc_o || bus.rsp_valid)), 0);
      chk("stb_eq_cyc", int'(bus.stb_o), int'(bus.cyc_o));
      if (!bus.stb_o) begin
        chk("we_outside_bus", int'(bus.we_o), 0);
      end else if (q.size() > 0) begin
        chk("bus_adr", int'(bus.adr_o), int'(q[0].adr));
        chk("bus_we", int'(bus.we_o), int'(q[0].we));
        chk("bus_dat", int'(bus.dat_o), q[0].we ? int'(q[0].wdat) : 0);
      end
      if (bus.rsp_valid) begin
        chk("rsp_expected", int'(q.size() > 0), 1);
        if (q.size() > 0) begin
          e = q.pop_front();
          chk("rsp_dat", int'(bus.rsp_dat), int'(e.dat));
          chk("rsp_err", int'(bus.rsp_err), int'(e.err));
          chk("rsp_cycle", cyc, e.rcyc);
          last_dat = e.dat;
          last_err = e.err;
        end
      end else begin
        chk("rsp_dat_hold", int'(bus.rsp_dat), int'(last_dat));
        chk("rsp_err_hold", int'(bus.rsp_err), int'(last_err));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  sel;
    logic [3:0]  lo;
    logic [15:0] a;
    int          a0;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_adr   = 16'h0000;
    bus.req_dat   = 8'h00;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", int'(bus.req_ready), 1);
    chk("rst_cyc", int'(bus.cyc_o), 0);
    chk("rst_stb", int'(bus.stb_o), 0);
    chk("rst_we", int'(bus.we_o), 0);
    chk("rst_rsp_valid", int'(bus.rsp_valid), 0);
    chk("rst_rsp_err", int'(bus.rsp_err), 0);
    chk("rst_adr", int'(bus.adr_o), 0);
    chk("rst_dat_o", int'(bus.dat_o), 0);
    chk("rst_rsp_dat", int'(bus.rsp_dat), 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    issue(1'b1, 16'h1234, 8'hA5, 0, 1'b0);
    drain();
    issue(1'b0, 16'h1234, 8'h3C, 0, 1'b0);
    drain();
`ifdef WB_MASTER_TIMEOUT_EN
    issue(1'b0, 16'h9000, 8'h00, 0, 1'b0);
    drain();
`else
    issue(1'b0, 16'h1234, 8'h00, 40, 1'b0);
    drain();
`endif
    issue(1'b0, 16'h1234, 8'h00, TO - 1, 1'b0);
    drain();

    issue(1'b1, 16'h2001, 8'h11, 0, 1'b1);
    a0 = acc_cyc;
    issue(1'b0, 16'h2001, 8'h00, 0, 1'b0);
    chk("b2b_spacing", acc_cyc - a0, 3);
    drain();

    // Abort a transfer to an absent slave with an asynchronous reset.
    issue(1'b0, 16'hA000, 8'h00, 0, 1'b0);
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_cyc", int'(bus.cyc_o), 0);
    chk("arst_stb", int'(bus.stb_o), 0);
    chk("arst_req_ready", int'(bus.req_ready), 1);
    chk("arst_rsp_valid", int'(bus.rsp_valid), 0);
    q.delete();
    last_dat = 8'h00;
    last_err = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    issue(1'b1, 16'h3007, 8'h77, 2, 1'b0);
    issue(1'b0, 16'h3007, 8'h00, 1, 1'b0);
    drain();

    for (int i = 0; i < 80; i++) begin
`ifdef WB_MASTER_TIMEOUT_EN
      sel = 4'($urandom_range(0, 15));
`else
      sel = 4'($urandom_range(0, 7));
`endif
      lo = 4'($urandom_range(0, 7));
      a  = {sel, 8'h00, lo};
      issue(1'($urandom), a, 8'($urandom), $urandom_range(0, 20), ($urandom_range(0, 3) == 0));
      if (!bus.req_valid) repeat ($urandom_range(0, 2)) @(posedge clk);
    end
    bus.req_valid = 1'b0;
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/wishbone_master.md
# wishbone_master

Single-outstanding-transaction Wishbone master that sits directly upstream of the memory-mapped Wishbone slaves on the shared 16-bit-address / 8-bit-data bus. It accepts simple read/write requests from a local requester (CPU core or test sequencer) through a valid/ready port. It drives one classic single-cycle Wishbone transfer per request and returns read data, or an error flag when no slave acknowledges, through a one-cycle response strobe. Slaves decode `adr_o[15:12]` as the slave select.

## Interface
- `TIMEOUT`, 16: max cycles `stb_o` stays high without `ack_i` before the transfer is aborted; legal range 2..255.
- `clk_i`  in  1  single system clock; all state updates on its rising edge.
- `rst_i`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  request accepted on a rising edge where `req_valid && req_ready`.
- `req_we`  in  1  1 = write, 0 = read.
- `req_adr`  in  16  target address; bits [15:12] select the slave.
- `req_dat`  in  8  write data; ignored on reads.
- `rsp_valid`  out  1  one-cycle response strobe.
- `rsp_dat`  out  8  read data; 8'h00 on writes and on error.
- `rsp_err`  out  1  1 = transfer timed out; qualified by `rsp_valid`.
- `adr_o`  out  16  Wishbone address.
- `we_o`  out  1  Wishbone write enable.
- `stb_o`  out  1  Wishbone strobe.
- `cyc_o`  out  1  Wishbone cycle.
- `dat_o`  out  8  Wishbone write data.
- `dat_i`  in  8  Wishbone read data.
- `ack_i`  in  1  Wishbone acknowledge. Unaddressed slaves may float it, so only a sampled value of exactly 1'b1 counts as an acknowledge; 0, X and Z count as no acknowledge.

## Operation
- FSM states:
  - IDLE: `req_ready` = 1.
  - BUS: `cyc_o` = `stb_o` = 1.
  - RESP: `rsp_valid` = 1.
- `req_ready` is combinational and is 1 only in IDLE.
- IDLE → BUS on accept. On that edge, register:
  - `req_adr` → `adr_o`
  - `req_we` → `we_o`
  - `req_dat` → `dat_o` (writes only; 8'h00 for reads)
  - clear the timeout counter.
- `adr_o`, `we_o` and `dat_o` are held constant for the whole of BUS.
- BUS → RESP on an edge where `ack_i` === 1:
  - drop `cyc_o`/`stb_o`;
  - `rsp_err` = 0;
  - `rsp_dat` = `dat_i` if read, 8'h00 if write.
- BUS, no ack: the counter increments each cycle. When the counter equals TIMEOUT-1 and there is still no ack, go to RESP with `rsp_err` = 1 and `rsp_dat` = 8'h00.
- Ack on the same edge as the timeout: ack wins, `rsp_err` = 0.
- RESP → IDLE unconditionally after one cycle. `rsp_valid` deasserts; `rsp_dat`/`rsp_err` hold until the next response.
- Counter width is $clog2(TIMEOUT); the counter never wraps because it is cleared on entering BUS.
- Reset values:
  - state IDLE, so `req_ready` = 1;
  - `cyc_o`, `stb_o`, `we_o`, `rsp_valid`, `rsp_err` = 0;
  - `adr_o` = 16'h0000; `dat_o`, `rsp_dat` = 8'h00.
- Reset mid-transfer drops `cyc_o`/`stb_o` immediately (asynchronously). No response is produced for the aborted request.

## Timing
- Request accepted at edge 0.
- `cyc_o`/`stb_o` high from edge 0 through the edge that samples the ack.
- With a combinational-ack slave, the ack is sampled at edge 1, `rsp_valid` is high between edges 1 and 2, and `req_ready` returns at edge 2.
- Minimum request-to-request spacing: 3 cycles.
- Worst case, no slave: `stb_o` high for TIMEOUT cycles, then a 1-cycle RESP.

## Configuration
- `WB_MASTER_TIMEOUT_EN`:
  - Defined: timeout counter and error path as above.
  - Undefined: the counter is not instantiated, BUS waits indefinitely for ack, `rsp_err` is tied to 0, and `TIMEOUT` is ignored.

## Test plan
- Write: `req_adr`=16'h1234, `req_dat`=8'hA5, slave at 4'h1 with combinational ack → `adr_o`=16'h1234, `dat_o`=8'hA5, `we_o`=1 for exactly one cycle; `rsp_valid` pulse at edge 2 with `rsp_err`=0, `rsp_dat`=8'h00.
- Read: 16'h1234 returns 8'hA5 from the slave → `rsp_dat`=8'hA5, `rsp_err`=0, `we_o`=0 throughout.
- Timeout (macro defined, TIMEOUT=16): read from 16'h9000, no slave, `ack_i` floating Z → `stb_o` high 16 cycles, then `rsp_err`=1, `rsp_dat`=8'h00, `req_ready`=1 one cycle later.
- Ack on the timeout cycle: ack on the 16th BUS cycle → `rsp_err`=0 with slave data returned.
- Back-to-back: `req_valid` held high with two requests → second accepted only when `req_ready` returns, 3 cycles after the first; `req_ready` never high outside IDLE.
- Reset mid-transfer: assert `rst_i` during BUS with no ack → `cyc_o`/`stb_o` fall without waiting for a clock edge, no `rsp_valid`, `req_ready`=1 after release; a new request completes normally.
